// File: rtl/digital_tube_pkg.sv
// Shared constants and nibble-to-segment decode for the 7-segment scanner.
package digital_tube_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/digital_tube_scanner_hex7seg.sv
// Combinational nibble + decimal point to active-low {dp,g,f,e,d,c,b,a}.
module hex7seg
  import digital_tube_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  // Decode the nibble and invert the dp flag into the active-low dp segment
  always_comb begin
    seg = {~dp, hex2seg(nib)};
  end

endmodule

// File: rtl/digital_tube_scanner.sv
// Four-digit time-multiplexed common-anode display driver.
module digital_tube_scanner
  import digital_tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  output logic [3:0] sel,
  output logic [7:0] dig
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    dig_q, dig_d;
  logic          tick;
  logic [3:0]    nib_mux;
  logic          dp_mux;
  logic [7:0]    seg_dec;

  hex7seg u_hex7seg (
    .nib (nib_mux),
    .dp  (dp_mux),
    .seg (seg_dec)
  );

  // Prescaler, digit index and decode of the currently selected digit
  always_comb begin
    tick        = (prescaler_q == LAST);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    nib_mux     = d0;
    dp_mux      = dp_in[idx_q];
    case (idx_q)
      2'd0:    nib_mux = d0;
      2'd1:    nib_mux = d1;
      2'd2:    nib_mux = d2;
      default: nib_mux = d3;
    endcase
    sel_d        = SEL_OFF;
    sel_d[idx_q] = 1'b0;
    dig_d        = seg_dec;
  end

  // State and registered display outputs; reset forces everything off
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      sel_q       <= SEL_OFF;
      dig_q       <= SEG_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      dig_q       <= dig_d;
    end
  end

  assign sel = sel_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_digital_tube_scanner.sv
// Self-checking bench for digital_tube_scanner with SCAN_DIV=4.
module tb_digital_tube_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d0, d1, d2, d3, dp_in;
  logic [3:0] sel;
  logic [7:0] dig;

  int checks   = 0;
  int failures = 0;
  int k        = 0;   // rising edges since reset release

  digital_tube_scanner #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .dp_in (dp_in),
    .sel   (sel),
    .dig   (dig)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Slot shown after edge n: each slot lasts SD edges, first edge shows slot 0
  function automatic int slot_of(input int n);
    return ((n - 1) / SD) % 4;
  endfunction

  function automatic logic [3:0] exp_sel(input int n);
    return ~(4'b0001 << slot_of(n));
  endfunction

  function automatic logic [7:0] exp_dig(input int n);
    logic [3:0] vals [4];
    int s;
    vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
    s = slot_of(n);
    return {~dp_in[s], ref_seg(vals[s])};
  endfunction

  // Advance one edge; sample #1 later. Inputs set now are seen by this edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8; dp_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sel !== 4'hF || dig !== 8'hFF) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d sel=%h dig=%h required sel=F dig=FF", i, sel, dig);
      end
    end
    rst = 1'b0;
    k = 0;
    step();
    checks++;
    if (sel !== 4'hE || dig !== {1'b0, ref_seg(4'h5)}) begin
      failures++;
      $display("FAIL reset_release sel=%h dig=%h required sel=E dig=%h", sel, dig, {1'b0, ref_seg(4'h5)});
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] want [4];
    want[0] = 8'hB0; want[1] = 8'hF8; want[2] = 8'h8E; want[3] = 8'h83;
    d0 = 4'h3; d1 = 4'h7; d2 = 4'hF; d3 = 4'hB; dp_in = 4'h0;
    do_reset();
    for (int i = 0; i < 2 * 4 * SD; i++) begin
      step();
      checks++;
      if (sel !== exp_sel(k) || dig !== want[slot_of(k)]) begin
        failures++;
        $display("FAIL scan_order k=%0d sel=%h dig=%h required sel=%h dig=%h",
                 k, sel, dig, exp_sel(k), want[slot_of(k)]);
      end
    end
  endtask

  task automatic test_live_update();
    logic [3:0] seq  [4];
    logic [7:0] want [4];
    seq[0] = 4'h1; seq[1] = 4'h3; seq[2] = 4'h6; seq[3] = 4'h7;
    want[0] = 8'hF9; want[1] = 8'hB0; want[2] = 8'h82; want[3] = 8'hF8;
    dp_in = 4'h0;
    d0 = 4'h1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d0 = seq[i];
      step();
      checks++;
      if (sel !== 4'hE || dig !== want[i]) begin
        failures++;
        $display("FAIL live_update i=%0d sel=%h dig=%h required sel=E dig=%h", i, sel, dig, want[i]);
      end
    end
  endtask

  task automatic test_dp();
    d0 = 4'h8; d1 = 4'h8; d2 = 4'h8; d3 = 4'h8; dp_in = 4'b1011;
    do_reset();
    for (int i = 0; i < 4 * SD; i++) begin
      step();
      checks++;
      if (dig[7] !== (slot_of(k) == 2) || sel !== exp_sel(k)) begin
        failures++;
        $display("FAIL dp k=%0d dig7=%b sel=%h required dig7=%b sel=%h",
                 k, dig[7], sel, (slot_of(k) == 2), exp_sel(k));
      end
    end
  endtask

  task automatic test_full_table();
    dp_in = 4'h0;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      d0 = 4'(v); d1 = 4'(v); d2 = 4'(v); d3 = 4'(v);
      step();
      checks++;
      if (dig[6:0] !== ref_seg(4'(v))) begin
        failures++;
        $display("FAIL seg_table v=%h dig=%h required %h", v, dig[6:0], ref_seg(4'(v)));
      end
    end
  endtask

  task automatic test_midscan_reset();
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4; dp_in = 4'h0;
    do_reset();
    while (k < 2 * SD + 2) step();   // inside the digit-2 slot
    rst = 1'b1;
    step();
    checks++;
    if (sel !== 4'hF || dig !== 8'hFF) begin
      failures++;
      $display("FAIL midscan_reset sel=%h dig=%h required sel=F dig=FF", sel, dig);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < SD + 1; i++) begin
      step();
      checks++;
      if (sel !== exp_sel(k) || dig !== exp_dig(k)) begin
        failures++;
        $display("FAIL midscan_restart k=%0d sel=%h dig=%h required sel=%h dig=%h",
                 k, sel, dig, exp_sel(k), exp_dig(k));
      end
    end
  endtask

  task automatic test_reset_on_tick();
    d0 = 4'h9; d1 = 4'hA; d2 = 4'hC; d3 = 4'hD; dp_in = 4'h5;
    do_reset();
    while (k < SD - 1) step();       // next edge is the slot-0 tick edge
    rst = 1'b1;
    step();
    checks++;
    if (sel !== 4'hF || dig !== 8'hFF) begin
      failures++;
      $display("FAIL reset_on_tick sel=%h dig=%h required sel=F dig=FF", sel, dig);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < SD + 1; i++) begin
      step();
      checks++;
      if (sel !== exp_sel(k) || dig !== exp_dig(k)) begin
        failures++;
        $display("FAIL reset_on_tick_restart k=%0d sel=%h dig=%h required sel=%h dig=%h",
                 k, sel, dig, exp_sel(k), exp_dig(k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      dp_in = 4'($urandom);
      step();
      checks++;
      if (sel !== exp_sel(k) || dig !== exp_dig(k)) begin
        failures++;
        $display("FAIL random k=%0d sel=%h dig=%h required sel=%h dig=%h",
                 k, sel, dig, exp_sel(k), exp_dig(k));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; dp_in = '0;
    test_reset();
    test_scan_order();
    test_live_update();
    test_dp();
    test_full_table();
    test_midscan_reset();
    test_reset_on_tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
